// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA/debug loader), the arbiter
// and the single-port data memory.
//   cpu_*  : CPU request (req/we/addr/wdata) and response (gnt/rvalid/rdata)
//   dma_*  : same set for the DMA/debug loader port
//   mem_*  : memory strobe/write-enable/address/write-data out, read data in
// Modports:
//   slave  : the arbiter (consumes requests, drives grants and the memory side)
//   master : the environment (requesters plus the memory itself)
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU
// load/store path (fixed priority) and a DMA/debug loader port. The DMA port
// is forced a slot after STARVE_LIMIT consecutive denied cycles.
// One access granted per cycle; read data returns one cycle after the grant.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : synchronous, active-high reset
//   bus  : dmem_arbiter_if.slave (cpu_*, dma_*, mem_* groups)
// STARVE_LIMIT legal range 1..15 (4-bit starvation counter).
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);

  logic [3:0] starve_cnt;
  logic       force_dma;
  logic       cpu_gnt;
  logic       dma_gnt;
  logic       rd_cpu;
  logic       rd_dma;
  logic       cpu_rvalid;
  logic       dma_rvalid;

  always_comb begin
    force_dma = bus.dma_req && (starve_cnt == 4'(STARVE_LIMIT));
    cpu_gnt   = bus.cpu_req && !force_dma && !rst;
    dma_gnt   = bus.dma_req && !cpu_gnt && !rst;
  end

  assign bus.cpu_gnt = cpu_gnt;
  assign bus.dma_gnt = dma_gnt;

  // Memory side follows the granted port; idle bus is all zeros.
  always_comb begin
    bus.mem_en    = cpu_gnt || dma_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  // Counts consecutive cycles the DMA port asked and lost; any gap in the
  // request or a DMA grant restarts the count.
  always_ff @(posedge clk) begin
    if (rst || dma_gnt || !bus.dma_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cpu <= 1'b0;
      rd_dma <= 1'b0;
    end else begin
      rd_cpu <= cpu_gnt && !bus.cpu_we;
      rd_dma <= dma_gnt && !bus.dma_we;
    end
  end

  // Gating with rst kills the return of a read granted the cycle before
  // reset is raised, since rd_* only clears on the following edge.
  assign cpu_rvalid     = rd_cpu && !rst;
  assign dma_rvalid     = rd_dma && !rst;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = dma_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model
// (denied-cycle count, pending read values, shadow memory).
module tb_dmem_arbiter;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 16;
  localparam int unsigned LIM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment memory: synchronous single-port RAM.
  logic [DW-1:0] mem     [2**AW];
  // Reference model state.
  logic [DW-1:0] ref_mem [2**AW];
  int            denied;
  bit            pend_c, pend_d;
  logic [DW-1:0] pend_cd, pend_dd;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent step, for directed checks.
  logic          last_cg, last_dg, last_cv, last_en;
  logic [DW-1:0] last_cd;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata     <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r,
                      input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                      input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    bit            force_d, eg_c, eg_d, e_en, e_we, ev_c, ev_d;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    rst           = r;
    bus.cpu_req   = cr;  bus.cpu_we = cw;  bus.cpu_addr = ca;  bus.cpu_wdata = cwd;
    bus.dma_req   = dr;  bus.dma_we = dw;  bus.dma_addr = da;  bus.dma_wdata = dwd;
    #1;
    force_d = dr && (denied >= int'(LIM));
    eg_c    = !r && cr && !force_d;
    eg_d    = !r && dr && !eg_c;
    e_en    = eg_c || eg_d;
    e_we    = eg_c ? cw  : (eg_d ? dw  : 1'b0);
    e_addr  = eg_c ? ca  : (eg_d ? da  : '0);
    e_wd    = eg_c ? cwd : (eg_d ? dwd : '0);
    ev_c    = pend_c && !r;
    ev_d    = pend_d && !r;

    chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(eg_c));
    chk("dma_gnt",    32'(bus.dma_gnt),    32'(eg_d));
    chk("one_grant",  32'(bus.cpu_gnt & bus.dma_gnt), 32'd0);
    chk("mem_en",     32'(bus.mem_en),     32'(e_en));
    chk("mem_we",     32'(bus.mem_we),     32'(e_we));
    chk("mem_addr",   32'(bus.mem_addr),   32'(e_addr));
    chk("mem_wdata",  32'(bus.mem_wdata),  32'(e_wd));
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(ev_c));
    chk("cpu_rdata",  32'(bus.cpu_rdata),  ev_c ? 32'(pend_cd) : 32'd0);
    chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(ev_d));
    chk("dma_rdata",  32'(bus.dma_rdata),  ev_d ? 32'(pend_dd) : 32'd0);

    last_cg = bus.cpu_gnt;  last_dg = bus.dma_gnt;  last_en = bus.mem_en;
    last_cv = bus.cpu_rvalid;  last_cd = bus.cpu_rdata;

    // Advance the model across the coming clock edge.
    pend_c = eg_c && !cw;
    pend_d = eg_d && !dw;
    if (pend_c) pend_cd = ref_mem[ca];
    if (pend_d) pend_dd = ref_mem[da];
    if (eg_c && cw) ref_mem[ca] = cwd;
    if (eg_d && dw) ref_mem[da] = dwd;
    if (r || !dr || eg_d) denied = 0;
    else if (denied < int'(LIM)) denied++;
  endtask

  task automatic idle(input bit r);
    step(r, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    bit            hc, hd, cr, cw, dr, dw, r;
    logic [AW-1:0] ca, da;
    logic [DW-1:0] cwd, dwd;

    for (int unsigned i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    mem[5] = 16'hBEEF;
    for (int unsigned i = 0; i < 2**AW; i++) ref_mem[i] = mem[i];
    bus.mem_rdata = '0;
    denied = 0; pend_c = 0; pend_d = 0; pend_cd = '0; pend_dd = '0;

    // Reset, including requests held during reset (no grant may appear).
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 10'd7, '0, 1'b1, 1'b0, 10'd8, '0);
    idle(1'b0);

    // 1: CPU read of address 5.
    step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0);
    chk("t1_gnt", 32'(last_cg), 32'd1);
    idle(1'b0);
    chk("t1_rvalid", 32'(last_cv), 32'd1);
    chk("t1_rdata",  32'(last_cd), 32'hBEEF);

    // 2: both request continuously; DMA slot every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'(i), '0, 1'b1, 1'b0, 10'(100 + i), '0);
      chk("t2_dma_slot", 32'(last_dg), 32'((i == 4) || (i == 9)));
    end
    idle(1'b0);

    // 3: DMA write then CPU read of the same address.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'd3, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 10'd3, '0, 1'b0, 1'b0, '0, '0);
    idle(1'b0);
    chk("t3_rdata", 32'(last_cd), 32'h1234);

    // 4: DMA drops after two denied cycles; count restarts on reassertion.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd21, '0);
    step(1'b0, 1'b1, 1'b0, 10'd20, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd21, '0);
      chk("t4_dma_slot", 32'(last_dg), 32'(i == 4));
    end
    idle(1'b0);

    // 5: read granted, reset raised the next cycle.
    step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0);
    chk("t5_rvalid_killed", 32'(last_cv), 32'd0);
    idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0);
    chk("t5_resume_gnt", 32'(last_cg), 32'd1);

    // 6: ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      chk("t6_idle_en", 32'(last_en), 32'd0);
    end

    // Randomized traffic; requests are held with their attributes until granted.
    hc = 0; hd = 0;
    cr = 0; cw = 0; ca = '0; cwd = '0; dr = 0; dw = 0; da = '0; dwd = '0;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 49) == 0);
      if (!hc) begin
        cr = ($urandom_range(0, 9) < 7); cw = $urandom_range(0, 1) == 1;
        ca = AW'($urandom_range(0, 15)); cwd = DW'($urandom);
      end
      if (!hd) begin
        dr = ($urandom_range(0, 9) < 5); dw = $urandom_range(0, 1) == 1;
        da = AW'($urandom_range(0, 15)); dwd = DW'($urandom);
      end
      step(r, cr, cw, ca, cwd, dr, dw, da, dwd);
      hc = cr && !last_cg;
      hd = dr && !last_dg;
    end
    idle(1'b0);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
